// File: rtl/ifill_router.sv
// ifill_router
//   Routes iCache line-fill requests to the boot ROM or to L2 by physical
//   address. Each accepted request produces exactly one registered fill
//   response. A timer guards each transaction: on expiry err_o is set and the
//   FSM returns to IDLE with no response. Requests that arrive while busy are
//   parked in a one-entry pending slot, and the newest request overwrites it.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   ic_req_valid_i/ic_req_paddr_i     iCache fill request (pulse + address)
//   ic_resp_valid_o/ic_resp_data_o    fill response pulse + line (data held)
//   brom_req_valid_o/brom_req_addr_o  boot ROM request, held until brom_ready_i
//   brom_ready_i                      boot ROM accepts the request
//   brom_resp_valid_i/brom_resp_data_i  boot ROM response
//   l2_req_valid_o/l2_req_paddr_o     L2 request, one-cycle pulse
//   l2_resp_valid_i/l2_resp_data_i    L2 response
//   busy_o                            FSM not IDLE
//   err_o                             sticky timeout flag
//
// Optional feature: define IFILL_ROUTER_PERF_EN to add saturating counters
//   perf_brom_fills_o, perf_l2_fills_o and perf_dropped_o.

module ifill_router #(
  parameter int unsigned          PADDR_W    = 40,
  parameter int unsigned          LINE_W     = 128,
  parameter int unsigned          BROM_AW    = 24,
  parameter logic [PADDR_W-1:0]   BROM_LIMIT = PADDR_W'(32'h0001_0000),
  parameter int unsigned          TIMEOUT    = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ic_req_valid_i,
  input  logic [PADDR_W-1:0] ic_req_paddr_i,
  output logic               ic_resp_valid_o,
  output logic [LINE_W-1:0]  ic_resp_data_o,
  output logic               brom_req_valid_o,
  output logic [BROM_AW-1:0] brom_req_addr_o,
  input  logic               brom_ready_i,
  input  logic               brom_resp_valid_i,
  input  logic [LINE_W-1:0]  brom_resp_data_i,
  output logic               l2_req_valid_o,
  output logic [PADDR_W-1:0] l2_req_paddr_o,
  input  logic               l2_resp_valid_i,
  input  logic [LINE_W-1:0]  l2_resp_data_i,
`ifdef IFILL_ROUTER_PERF_EN
  output logic [31:0]        perf_brom_fills_o,
  output logic [31:0]        perf_l2_fills_o,
  output logic [31:0]        perf_dropped_o,
`endif
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned    TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BROM_REQ  = 3'd1,
    S_BROM_WAIT = 3'd2,
    S_L2_REQ    = 3'd3,
    S_L2_WAIT   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PADDR_W-1:0] r_paddr;
  logic               r_pend_valid;
  logic [PADDR_W-1:0] r_pend_paddr;
  logic [TW-1:0]      r_timer;
  logic               r_resp_valid;
  logic [LINE_W-1:0]  r_resp_data;
  logic               r_err;

  logic               w_req_valid;
  logic [PADDR_W-1:0] w_req_paddr;
  logic               w_brom_take;
  logic               w_l2_take;
  logic               w_timer_done;
  logic               w_timeout;
  logic               w_timed_state;

  // A fresh iCache request takes priority over the parked one
  assign w_req_valid   = ic_req_valid_i | r_pend_valid;
  assign w_req_paddr   = ic_req_valid_i ? ic_req_paddr_i : r_pend_paddr;
  assign w_brom_take   = (r_state == S_BROM_WAIT) & brom_resp_valid_i;
  assign w_l2_take     = (r_state == S_L2_WAIT) & l2_resp_valid_i;
  assign w_timer_done  = (r_timer == TMAX);
  assign w_timed_state = (r_state == S_BROM_REQ) | (r_state == S_BROM_WAIT) |
                         (r_state == S_L2_WAIT);
  // Progress (handshake or response) beats an expiring timer in the same cycle
  assign w_timeout     = w_timer_done &
                         (((r_state == S_BROM_REQ) & ~brom_ready_i) |
                          ((r_state == S_BROM_WAIT) & ~brom_resp_valid_i) |
                          ((r_state == S_L2_WAIT) & ~l2_resp_valid_i));

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_valid) begin
          if (w_req_paddr < BROM_LIMIT) w_state_next = S_BROM_REQ;
          else                          w_state_next = S_L2_REQ;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BROM_REQ: begin
        if (brom_ready_i)   w_state_next = S_BROM_WAIT;
        else if (w_timeout) w_state_next = S_IDLE;
        else                w_state_next = S_BROM_REQ;
      end
      S_BROM_WAIT: begin
        if (brom_resp_valid_i || w_timeout) w_state_next = S_IDLE;
        else                                w_state_next = S_BROM_WAIT;
      end
      S_L2_REQ: w_state_next = S_L2_WAIT;
      S_L2_WAIT: begin
        if (l2_resp_valid_i || w_timeout) w_state_next = S_IDLE;
        else                              w_state_next = S_L2_WAIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register; addresses read 0 when idle
  always_comb begin
    brom_req_valid_o = 1'b0;
    brom_req_addr_o  = {BROM_AW{1'b0}};
    l2_req_valid_o   = 1'b0;
    l2_req_paddr_o   = {PADDR_W{1'b0}};
    busy_o           = (r_state != S_IDLE);
    if (r_state == S_BROM_REQ) begin
      brom_req_valid_o = 1'b1;
      brom_req_addr_o  = r_paddr[BROM_AW-1:0];
    end else if (r_state == S_L2_REQ) begin
      l2_req_valid_o = 1'b1;
      l2_req_paddr_o = r_paddr;
    end else begin
      brom_req_valid_o = 1'b0;
      l2_req_valid_o   = 1'b0;
    end
  end

  // Transaction timer, cleared whenever the FSM changes state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         r_timer <= {TW{1'b0}};
    else if (w_state_next != r_state)  r_timer <= {TW{1'b0}};
    else if (w_timed_state)            r_timer <= r_timer + TW'(1);
    else                               r_timer <= {TW{1'b0}};
  end

  // Active address latch and the one-entry pending slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_paddr      <= {PADDR_W{1'b0}};
      r_pend_valid <= 1'b0;
      r_pend_paddr <= {PADDR_W{1'b0}};
    end else if (r_state == S_IDLE) begin
      if (w_req_valid) r_paddr <= w_req_paddr;
      // The slot is consumed only when it was actually the one issued
      if (!ic_req_valid_i) r_pend_valid <= 1'b0;
    end else if (ic_req_valid_i) begin
      r_pend_valid <= 1'b1;
      r_pend_paddr <= ic_req_paddr_i;
    end
  end

  // Registered fill response and sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= {LINE_W{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= w_brom_take | w_l2_take;
      if (w_brom_take)    r_resp_data <= brom_resp_data_i;
      else if (w_l2_take) r_resp_data <= l2_resp_data_i;
      if (w_timeout)      r_err <= 1'b1;
    end
  end

  assign ic_resp_valid_o = r_resp_valid;
  assign ic_resp_data_o  = r_resp_data;
  assign err_o           = r_err;

`ifdef IFILL_ROUTER_PERF_EN
  logic [31:0] r_perf_brom;
  logic [31:0] r_perf_l2;
  logic [31:0] r_perf_drop;
  logic [1:0]  w_drop_n;

  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Both sources can drop a response in the same cycle
  assign w_drop_n = {1'b0, brom_resp_valid_i & ~w_brom_take} +
                    {1'b0, l2_resp_valid_i & ~w_l2_take};

  // Saturating fill and drop counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_brom <= 32'd0;
      r_perf_l2   <= 32'd0;
      r_perf_drop <= 32'd0;
    end else begin
      r_perf_brom <= sat_add(r_perf_brom, {1'b0, w_brom_take});
      r_perf_l2   <= sat_add(r_perf_l2, {1'b0, w_l2_take});
      r_perf_drop <= sat_add(r_perf_drop, w_drop_n);
    end
  end

  assign perf_brom_fills_o = r_perf_brom;
  assign perf_l2_fills_o   = r_perf_l2;
  assign perf_dropped_o    = r_perf_drop;
`endif

endmodule

// File: tb/tb_ifill_router.sv
module tb_ifill_router;

  localparam logic [39:0] LIMIT = 40'h00_0001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         ic_req_valid_i = 1'b0;
  logic [39:0]  ic_req_paddr_i = 40'h0;
  logic         ic_resp_valid_o;
  logic [127:0] ic_resp_data_o;
  logic         brom_req_valid_o;
  logic [23:0]  brom_req_addr_o;
  logic         brom_ready_i = 1'b0;
  logic         brom_resp_valid_i = 1'b0;
  logic [127:0] brom_resp_data_i = 128'h0;
  logic         l2_req_valid_o;
  logic [39:0]  l2_req_paddr_o;
  logic         l2_resp_valid_i = 1'b0;
  logic [127:0] l2_resp_data_i = 128'h0;
  logic         busy_o;
  logic         err_o;
`ifdef IFILL_ROUTER_PERF_EN
  logic [31:0]  perf_brom_fills_o;
  logic [31:0]  perf_l2_fills_o;
  logic [31:0]  perf_dropped_o;
`endif

  ifill_router #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_paddr_i(ic_req_paddr_i),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
    .brom_req_valid_o(brom_req_valid_o), .brom_req_addr_o(brom_req_addr_o),
    .brom_ready_i(brom_ready_i),
    .brom_resp_valid_i(brom_resp_valid_i), .brom_resp_data_i(brom_resp_data_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_paddr_o(l2_req_paddr_o),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_data_i(l2_resp_data_i),
`ifdef IFILL_ROUTER_PERF_EN
    .perf_brom_fills_o(perf_brom_fills_o), .perf_l2_fills_o(perf_l2_fills_o),
    .perf_dropped_o(perf_dropped_o),
`endif
    .busy_o(busy_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation queues filled by the monitor
  logic [127:0] resp_q[$];
  int           resp_cyc_q[$];
  logic [39:0]  l2_q[$];
  logic [23:0]  brom_q[$];

  always @(negedge clk) begin
    if (ic_resp_valid_o) begin resp_q.push_back(ic_resp_data_o); resp_cyc_q.push_back(cyc); end
    if (l2_req_valid_o) l2_q.push_back(l2_req_paddr_o);
    if (brom_req_valid_o) brom_q.push_back(brom_req_addr_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Measurements of the last do_fill
  int           m_nresp, m_lat, m_nl2, m_nbrom;
  logic [127:0] m_data;
  logic [39:0]  m_l2_first;
  logic [23:0]  m_brom_first, m_brom_last;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_q();
    resp_q.delete(); resp_cyc_q.delete(); l2_q.delete(); brom_q.delete();
  endtask

  // Reference routing rule
  function automatic bit model_is_brom(input logic [39:0] a);
    return a < LIMIT;
  endfunction

  task automatic drive_other(input bit to_brom, input logic [127:0] d, input bit v);
    if (to_brom) begin l2_resp_valid_i = v; l2_resp_data_i = d; end
    else begin brom_resp_valid_i = v; brom_resp_data_i = d; end
  endtask

  // Runs one scripted fill: rw cycles before ROM ready, dw idle wait cycles,
  // optional response from the other source at wait cycle spur_at
  task automatic do_fill(input logic [39:0] paddr, input int rw, input int dw,
                         input logic [127:0] d_sel, input logic [127:0] d_oth,
                         input int spur_at);
    bit to_brom;
    int t0;
    to_brom = model_is_brom(paddr);
    clear_q();
    ic_req_valid_i = 1'b1; ic_req_paddr_i = paddr; t0 = cyc;
    tick();
    ic_req_valid_i = 1'b0;
    if (to_brom) begin
      repeat (rw) tick();
      brom_ready_i = 1'b1; tick(); brom_ready_i = 1'b0;
    end else begin
      tick();
    end
    for (int k = 0; k < dw; k++) begin
      if (k == spur_at) drive_other(to_brom, d_oth, 1'b1);
      tick();
      drive_other(to_brom, d_oth, 1'b0);
    end
    if (to_brom) begin brom_resp_valid_i = 1'b1; brom_resp_data_i = d_sel; end
    else begin l2_resp_valid_i = 1'b1; l2_resp_data_i = d_sel; end
    if (spur_at == dw) drive_other(to_brom, d_oth, 1'b1);
    tick();
    brom_resp_valid_i = 1'b0; l2_resp_valid_i = 1'b0;
    tick(); tick();
    m_nresp = resp_q.size();
    m_data  = (m_nresp > 0) ? resp_q[0] : 128'h0;
    m_lat   = (m_nresp > 0) ? resp_cyc_q[0] - t0 : -1;
    m_nl2   = l2_q.size();
    m_l2_first = (m_nl2 > 0) ? l2_q[0] : 40'h0;
    m_nbrom = brom_q.size();
    m_brom_first = (m_nbrom > 0) ? brom_q[0] : 24'h0;
    m_brom_last  = (m_nbrom > 0) ? brom_q[m_nbrom-1] : 24'h0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (ic_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", ic_resp_valid_o); end
    n_checks++; if (ic_resp_data_o !== 128'h0) begin n_fail++; $display("FAIL rst_resp_data got=%h exp=0", ic_resp_data_o); end
    n_checks++; if (brom_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_brom_valid got=%b exp=0", brom_req_valid_o); end
    n_checks++; if (brom_req_addr_o !== 24'h0) begin n_fail++; $display("FAIL rst_brom_addr got=%h exp=0", brom_req_addr_o); end
    n_checks++; if (l2_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_l2_valid got=%b exp=0", l2_req_valid_o); end
    n_checks++; if (l2_req_paddr_o !== 40'h0) begin n_fail++; $display("FAIL rst_l2_paddr got=%h exp=0", l2_req_paddr_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_brom_fill();
    logic [127:0] d;
    d = {16{8'hA5}};
    do_fill(40'h100, 1, 0, d, rnd128(), -1);
    n_checks++; if (m_nbrom !== 2) begin n_fail++; $display("FAIL brom_req_cycles got=%0d exp=2", m_nbrom); end
    n_checks++; if (m_brom_first !== 24'h100 || m_brom_last !== 24'h100) begin n_fail++; $display("FAIL brom_addr got=%h/%h exp=100", m_brom_first, m_brom_last); end
    n_checks++; if (m_nresp !== 1) begin n_fail++; $display("FAIL brom_nresp got=%0d exp=1", m_nresp); end
    n_checks++; if (m_data !== d) begin n_fail++; $display("FAIL brom_data got=%h exp=%h", m_data, d); end
    n_checks++; if (m_nl2 !== 0) begin n_fail++; $display("FAIL brom_no_l2 got=%0d exp=0", m_nl2); end
    n_checks++; if (m_lat !== 4) begin n_fail++; $display("FAIL brom_latency got=%0d exp=4", m_lat); end
  endtask

  task automatic test_l2_fill();
    logic [127:0] d;
    d = rnd128();
    do_fill(40'h00_8000_0000, 0, 5, d, rnd128(), -1);
    n_checks++; if (m_nl2 !== 1) begin n_fail++; $display("FAIL l2_pulses got=%0d exp=1", m_nl2); end
    n_checks++; if (m_l2_first !== 40'h00_8000_0000) begin n_fail++; $display("FAIL l2_paddr got=%h exp=8000_0000", m_l2_first); end
    n_checks++; if (m_nresp !== 1 || m_data !== d) begin n_fail++; $display("FAIL l2_resp got=%0d/%h exp=1/%h", m_nresp, m_data, d); end
    n_checks++; if (m_lat !== 8) begin n_fail++; $display("FAIL l2_latency got=%0d exp=8", m_lat); end
    n_checks++; if (m_nbrom !== 0) begin n_fail++; $display("FAIL l2_no_brom got=%0d exp=0", m_nbrom); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      logic [39:0]  a;
      logic [127:0] ds;
      int rw, dw, sp, exp_lat;
      bit brom;
      brom = ($urandom_range(0, 1) == 1);
      if (brom) begin
        a = {24'h0, 12'($urandom_range(0, 4095)), 4'h0};
      end else begin
        a = {8'($urandom), 26'($urandom), 6'h0};
        if (a < LIMIT) a = a | 40'h80_0000_0000;
      end
      rw = brom ? int'($urandom_range(0, 5)) : 0;
      dw = int'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) sp = int'($urandom_range(0, dw));
      else sp = -1;
      ds = rnd128();
      do_fill(a, rw, dw, ds, rnd128(), sp);
      exp_lat = 3 + rw + dw;
      n_checks++; if (m_nresp !== 1) begin n_fail++; $display("FAIL rnd_nresp it=%0d got=%0d exp=1", it, m_nresp); end
      n_checks++; if (m_data !== ds) begin n_fail++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, m_data, ds); end
      n_checks++; if (m_lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, m_lat, exp_lat); end
      n_checks++; if (m_nl2 !== (brom ? 0 : 1)) begin n_fail++; $display("FAIL rnd_l2_pulses it=%0d got=%0d exp=%0d", it, m_nl2, brom ? 0 : 1); end
      n_checks++; if (m_nbrom !== (brom ? rw + 1 : 0)) begin n_fail++; $display("FAIL rnd_brom_cycles it=%0d got=%0d exp=%0d", it, m_nbrom, brom ? rw + 1 : 0); end
      if (brom) begin
        n_checks++; if (m_brom_first !== a[23:0] || m_brom_last !== a[23:0]) begin n_fail++; $display("FAIL rnd_brom_addr it=%0d got=%h/%h exp=%h", it, m_brom_first, m_brom_last, a[23:0]); end
      end else begin
        n_checks++; if (m_l2_first !== a) begin n_fail++; $display("FAIL rnd_l2_addr it=%0d got=%h exp=%h", it, m_l2_first, a); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d[2];
    int served;
    d[0] = rnd128(); d[1] = rnd128();
    clear_q();
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_8000_0000; tick();
    ic_req_paddr_i = 40'h00_8000_0040; tick();
    ic_req_paddr_i = 40'h00_8000_0080; tick();
    ic_req_valid_i = 1'b0;
    l2_resp_valid_i = 1'b1; l2_resp_data_i = d[0]; tick();
    l2_resp_valid_i = 1'b0;
    served = 1;
    for (int i = 0; i < 40 && served < 2; i++) begin
      if (l2_req_valid_o) begin
        tick();
        l2_resp_valid_i = 1'b1; l2_resp_data_i = d[served]; tick();
        l2_resp_valid_i = 1'b0;
        served++;
      end else begin
        tick();
      end
    end
    repeat (4) tick();
    n_checks++; if (served !== 2) begin n_fail++; $display("FAIL b2b_served got=%0d exp=2", served); end
    n_checks++; if (resp_q.size() !== 2) begin n_fail++; $display("FAIL b2b_nresp got=%0d exp=2", resp_q.size()); end
    n_checks++; if (l2_q.size() !== 2) begin n_fail++; $display("FAIL b2b_nreq got=%0d exp=2", l2_q.size()); end
    if (l2_q.size() == 2) begin
      n_checks++; if (l2_q[0] !== 40'h00_8000_0000 || l2_q[1] !== 40'h00_8000_0080) begin n_fail++; $display("FAIL b2b_addrs got=%h,%h exp=80000000,80000080", l2_q[0], l2_q[1]); end
    end
    if (resp_q.size() == 2) begin
      n_checks++; if (resp_q[0] !== d[0] || resp_q[1] !== d[1]) begin n_fail++; $display("FAIL b2b_data got=%h,%h exp=%h,%h", resp_q[0], resp_q[1], d[0], d[1]); end
    end
  endtask

  task automatic test_drop();
    logic [127:0] d;
    d = rnd128();
    do_fill(40'h00_4000_0100, 0, 4, d, rnd128(), 1);
    n_checks++; if (m_nresp !== 1 || m_data !== d) begin n_fail++; $display("FAIL drop_midwait got=%0d/%h exp=1/%h", m_nresp, m_data, d); end
    begin
`ifdef IFILL_ROUTER_PERF_EN
      logic [31:0] base;
      base = perf_dropped_o;
`endif
      clear_q();
      brom_resp_valid_i = 1'b1; brom_resp_data_i = rnd128();
      l2_resp_valid_i = 1'b1; l2_resp_data_i = rnd128();
      tick();
      brom_resp_valid_i = 1'b0; l2_resp_valid_i = 1'b0;
      tick(); tick();
      n_checks++; if (resp_q.size() !== 0) begin n_fail++; $display("FAIL drop_idle_nresp got=%0d exp=0", resp_q.size()); end
      n_checks++; if (ic_resp_data_o !== d) begin n_fail++; $display("FAIL drop_data_hold got=%h exp=%h", ic_resp_data_o, d); end
`ifdef IFILL_ROUTER_PERF_EN
      n_checks++; if (perf_dropped_o !== base + 32'd2) begin n_fail++; $display("FAIL perf_dropped got=%0d exp=%0d", perf_dropped_o, base + 32'd2); end
`endif
    end
  endtask

  task automatic test_timeout();
    logic [127:0] d;
    clear_q();
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_8000_1000; tick();
    ic_req_valid_i = 1'b0;
    tick();                  // first cycle of L2_WAIT
    repeat (15) tick();      // wait cycle 15
    n_checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL to_before got=err%b/busy%b exp=err0/busy1", err_o, busy_o); end
    tick();                  // wait cycle 16
    n_checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL to_expire got=err%b/busy%b exp=err1/busy0", err_o, busy_o); end
    repeat (3) tick();
    n_checks++; if (resp_q.size() !== 0) begin n_fail++; $display("FAIL to_noresp got=%0d exp=0", resp_q.size()); end
    d = rnd128();
    do_fill(40'h200, 0, 1, d, rnd128(), -1);
    n_checks++; if (m_nresp !== 1 || m_data !== d) begin n_fail++; $display("FAIL to_after_fill got=%0d/%h exp=1/%h", m_nresp, m_data, d); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%b exp=1", err_o); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_9000_0000; tick();
    ic_req_valid_i = 1'b0;
    tick(); tick();          // in L2_WAIT
    rst = 1'b1; #1;
    n_checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got=busy%b/err%b exp=0/0", busy_o, err_o); end
    tick();
    rst = 1'b0;
    tick();
    l2_resp_valid_i = 1'b1; l2_resp_data_i = rnd128(); tick();
    l2_resp_valid_i = 1'b0;
    tick(); tick();
    n_checks++; if (resp_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_late got=%0d exp=0", resp_q.size()); end
    n_checks++; if (ic_resp_data_o !== 128'h0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs got=%h/busy%b exp=0/0", ic_resp_data_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_brom_fill();
    test_l2_fill();
    test_random();
    test_back_to_back();
    test_drop();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
